// File: rtl/fetch_pkg.sv
// Shared encodings and constants for the fetch-stage redirect controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StRedir  = 2'd2,
        StBubble = 2'd3
    } fetch_state_e;

    // Numeric order doubles as redirect priority.
    typedef enum logic [1:0] {
        SrcNone   = 2'd0,
        SrcJump   = 2'd1,
        SrcBranch = 2'd2,
        SrcTrap   = 2'd3
    } redir_src_e;

    localparam logic [31:0] RESET_PC            = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

    // ID/EX only holds a wrong-path instruction when the redirect comes from EX or a trap.
    function automatic logic src_flushes_ex(redir_src_e src);
        return (src == SrcBranch) || (src == SrcTrap);
    endfunction

endpackage

// File: rtl/redirect_arb.sv
// Combinational priority selector: trap over EX branch over ID jump.
module redirect_arb
    import fetch_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic        trap_req,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    output redir_src_e  src,
    output logic [31:0] target
);

    always_comb begin
        src    = SrcNone;
        target = RESET_PC;
        if (trap_req) begin
            src    = SrcTrap;
            target = TRAP_VECTOR;
        end else if (ex_br_taken) begin
            src    = SrcBranch;
            target = ex_br_target;
        end else if (id_jump) begin
            src    = SrcJump;
            target = id_jump_target;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage control: boot stall, prioritised PC redirects with pipeline flushes,
// post-redirect bubble and a count of completed redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hz_stall,
    input  logic        imem_ready,
    input  logic        trap_req,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    output logic        pc_src,
    output logic [31:0] target_pc,
    output logic        stall,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        fetch_valid,
    output logic [15:0] redirect_cnt
);

    fetch_state_e state_q, state_d;
    redir_src_e   src_q, src_d;
    redir_src_e   arb_src;
    logic [31:0]  arb_target;
    logic [15:0]  boot_cnt_q, boot_cnt_d;
    logic         pc_src_q, pc_src_d;
    logic [31:0]  target_q, target_d;
    logic         stall_q, stall_d;
    logic         flush_if_id_q, flush_if_id_d;
    logic         flush_id_ex_q, flush_id_ex_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         boot_done;

    redirect_arb #(
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_arb (
        .trap_req       (trap_req),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .id_jump        (id_jump),
        .id_jump_target (id_jump_target),
        .src            (arb_src),
        .target         (arb_target)
    );

    assign boot_done = (32'(boot_cnt_q) + 32'd1) >= BOOT_CYCLES;

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        boot_cnt_d    = boot_cnt_q;
        pc_src_d      = pc_src_q;
        target_d      = target_q;
        stall_d       = stall_q;
        flush_if_id_d = flush_if_id_q;
        flush_id_ex_d = flush_id_ex_q;
        cnt_d         = cnt_q;

        case (state_q)
            StBoot: begin
                boot_cnt_d    = boot_cnt_q + 16'd1;
                pc_src_d      = 1'b0;
                flush_if_id_d = 1'b0;
                flush_id_ex_d = 1'b0;
                stall_d       = 1'b1;
                if (boot_done) begin
                    state_d = StRun;
                    stall_d = hz_stall | ~imem_ready;
                end
            end
            StRun, StBubble: begin
                if (arb_src != SrcNone) begin
                    state_d       = StRedir;
                    src_d         = arb_src;
                    target_d      = arb_target;
                    pc_src_d      = 1'b1;
                    flush_if_id_d = 1'b1;
                    flush_id_ex_d = src_flushes_ex(arb_src);
                    stall_d       = 1'b0;
                end else begin
                    state_d       = StRun;
                    pc_src_d      = 1'b0;
                    flush_if_id_d = 1'b0;
                    flush_id_ex_d = 1'b0;
                    stall_d       = hz_stall | ~imem_ready;
                end
            end
            StRedir: begin
                stall_d = 1'b0;
                if (imem_ready) begin
                    // IFU consumes target_pc on this edge; the redirect is complete.
                    state_d       = StBubble;
                    src_d         = SrcNone;
                    pc_src_d      = 1'b0;
                    flush_if_id_d = 1'b0;
                    flush_id_ex_d = 1'b0;
                    cnt_d         = cnt_q + 16'd1;
                end else if ((arb_src != SrcNone) && (arb_src >= src_q)) begin
                    src_d         = arb_src;
                    target_d      = arb_target;
                    flush_id_ex_d = src_flushes_ex(arb_src);
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StBoot;
            src_q         <= SrcNone;
            boot_cnt_q    <= 16'd0;
            pc_src_q      <= 1'b0;
            target_q      <= RESET_PC;
            stall_q       <= 1'b1;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
            cnt_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            boot_cnt_q    <= boot_cnt_d;
            pc_src_q      <= pc_src_d;
            target_q      <= target_d;
            stall_q       <= stall_d;
            flush_if_id_q <= flush_if_id_d;
            flush_id_ex_q <= flush_id_ex_d;
            cnt_q         <= cnt_d;
        end
    end

    assign pc_src       = pc_src_q;
    assign target_pc    = target_q;
    assign stall        = stall_q;
    assign flush_if_id  = flush_if_id_q;
    assign flush_id_ex  = flush_id_ex_q;
    assign redirect_cnt = cnt_q;
    assign fetch_valid  = (state_q == StRun) & imem_ready;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver pushes model predictions, monitor pops and compares.
module tb_fetch_ctrl;

    localparam int unsigned BOOT = 2;
    localparam logic [31:0] TVEC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hz_stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        trap_req = 1'b0;
    logic        ex_br_taken = 1'b0;
    logic [31:0] ex_br_target = 32'h0;
    logic        id_jump = 1'b0;
    logic [31:0] id_jump_target = 32'h0;
    logic        pc_src;
    logic [31:0] target_pc;
    logic        stall;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        fetch_valid;
    logic [15:0] redirect_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        pc_src;
        logic [31:0] target;
        logic        stall;
        logic        fif;
        logic        fex;
        logic        fv;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: boot countdown, pending-redirect record, bubble flag, counter.
    int          m_boot_left;
    bit          m_redir;
    bit          m_bubble;
    int          m_prio;
    logic [31:0] m_tgt;
    int          m_cnt;

    always #5 clock = ~clock;

    fetch_ctrl #(
        .BOOT_CYCLES (BOOT),
        .TRAP_VECTOR (TVEC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .hz_stall       (hz_stall),
        .imem_ready     (imem_ready),
        .trap_req       (trap_req),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .id_jump        (id_jump),
        .id_jump_target (id_jump_target),
        .pc_src         (pc_src),
        .target_pc      (target_pc),
        .stall          (stall),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .fetch_valid    (fetch_valid),
        .redirect_cnt   (redirect_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            if (fails <= 20) $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_boot_left = BOOT;
        m_redir     = 1'b0;
        m_bubble    = 1'b0;
        m_prio      = 0;
        m_tgt       = 32'h0;
        m_cnt       = 0;
    endtask

    task automatic model_step(input bit hz, input bit rdy, input bit tr, input bit br,
                              input logic [31:0] bt, input bit jp, input logic [31:0] jt,
                              output exp_t e);
        int          rp;
        logic [31:0] rt;
        rp = tr ? 3 : (br ? 2 : (jp ? 1 : 0));
        rt = tr ? TVEC : (br ? bt : jt);
        e.pc_src = 1'b0;
        e.fif    = 1'b0;
        e.fex    = 1'b0;
        e.stall  = 1'b0;
        if (m_boot_left > 0) begin
            m_boot_left--;
            e.stall = (m_boot_left > 0) ? 1'b1 : (hz | !rdy);
        end else if (m_redir) begin
            if (rdy) begin
                m_redir  = 1'b0;
                m_bubble = 1'b1;
                m_cnt    = (m_cnt + 1) % 65536;
            end else begin
                if (rp > 0 && rp >= m_prio) begin
                    m_prio = rp;
                    m_tgt  = rt;
                end
                e.pc_src = 1'b1;
                e.fif    = 1'b1;
                e.fex    = (m_prio >= 2);
            end
        end else if (rp > 0) begin
            m_redir  = 1'b1;
            m_bubble = 1'b0;
            m_prio   = rp;
            m_tgt    = rt;
            e.pc_src = 1'b1;
            e.fif    = 1'b1;
            e.fex    = (rp >= 2);
        end else begin
            m_bubble = 1'b0;
            e.stall  = hz | !rdy;
        end
        e.target = m_tgt;
        e.cnt    = m_cnt[15:0];
        e.fv     = (m_boot_left == 0) && !m_redir && !m_bubble && rdy;
    endtask

    task automatic drive(input bit hz, input bit rdy, input bit tr, input bit br,
                         input logic [31:0] bt, input bit jp, input logic [31:0] jt);
        exp_t e;
        @(negedge clock);
        reset          = 1'b1;
        hz_stall       = hz;
        imem_ready     = rdy;
        trap_req       = tr;
        ex_br_taken    = br;
        ex_br_target   = bt;
        id_jump        = jp;
        id_jump_target = jt;
        model_step(hz, rdy, tr, br, bt, jp, jt, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_pc_src", 32'(pc_src), 32'd0);
        check("rst_target", target_pc, 32'h0);
        check("rst_flush_if_id", 32'(flush_if_id), 32'd0);
        check("rst_flush_id_ex", 32'(flush_id_ex), 32'd0);
        check("rst_cnt", 32'(redirect_cnt), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        model_reset();
        repeat (2) @(negedge clock);
    endtask

    // Monitor: compare every registered output one delta after each active edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("pc_src", 32'(pc_src), 32'(e.pc_src));
                check("target_pc", target_pc, e.target);
                check("stall", 32'(stall), 32'(e.stall));
                check("flush_if_id", 32'(flush_if_id), 32'(e.fif));
                check("flush_id_ex", 32'(flush_id_ex), 32'(e.fex));
                check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
                check("redirect_cnt", 32'(redirect_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // Boot: two stalled cycles, then running with valid fetch
        idle(4);
        // EX branch to 0x0C, completes immediately
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 32'h0);
        idle(3);
        // Trap beats a same-cycle jump
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        idle(3);
        // Held redirect, higher-priority overwrite while memory not ready
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(2);
        // Lower-priority jump dropped while a branch is pending
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0088);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(2);
        // Hazard stall, then hazard overridden by a jump
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0080);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            bit hz;
            bit rdy;
            bit tr;
            bit br;
            bit jp;
            hz  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tr  = ($urandom_range(0, 19) == 0);
            br  = ($urandom_range(0, 6) == 0);
            jp  = ($urandom_range(0, 6) == 0);
            drive(hz, rdy, tr, br, $urandom() & 32'hFFFF_FFFC, jp, $urandom() & 32'hFFFF_FFFC);
        end

        // Reset while a redirect is pending discards it
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        do_reset();
        idle(3);

        // Counter wrap: 65535 redirects, then one more
        for (int i = 0; i < 65536; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        @(posedge clock);
        #2;
        check("wrap_cnt", 32'(redirect_cnt), 32'd0);
        idle(2);

        @(posedge clock);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 2, meaning cycles stall is held after reset release.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning redirect target for trap_req.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port hz_stall  input  1  hazard-unit stall request (load-use).
REQ-006 SHALL have port imem_ready  input  1  instruction memory can deliver this cycle.
REQ-007 SHALL have port trap_req  input  1  trap/exception redirect request.
REQ-008 SHALL have port ex_br_taken  input  1  EX-stage branch resolved taken.
REQ-009 SHALL have port ex_br_target  input  32  EX-stage branch target.
REQ-010 SHALL have port id_jump  input  1  ID-stage JAL redirect request.
REQ-011 SHALL have port id_jump_target  input  32  ID-stage jump target.
REQ-012 SHALL have port pc_src  output  1  to IFU: load target_pc on next edge.
REQ-013 SHALL have port target_pc  output  32  to IFU: redirect address.
REQ-014 SHALL have port stall  output  1  to IFU: hold PC.
REQ-015 SHALL have port flush_if_id  output  1  squash IF/ID register.
REQ-016 SHALL have port flush_id_ex  output  1  squash ID/EX register.
REQ-017 SHALL have port fetch_valid  output  1  instruction in IF is valid.
REQ-018 SHALL have port redirect_cnt  output  16  count of completed redirects.

Function
REQ-019 SHALL implement FSM states BOOT, RUN, REDIR, BUBBLE; all outputs registered except fetch_valid.
REQ-020 BOOT SHALL hold stall=1, pc_src=0 for BOOT_CYCLES edges after reset release, then enter RUN.
REQ-021 Redirect priority SHALL be trap_req > ex_br_taken > id_jump; target = TRAP_VECTOR / ex_br_target / id_jump_target respectively.
REQ-022 In RUN, a redirect sampled at edge N SHALL enter REDIR with pc_src=1, target_pc latched, flush_if_id=1 in cycle N+1 (latency 1).
REQ-023 flush_id_ex SHALL be 1 in REDIR only for trap or EX-branch sources, 0 for id_jump.
REQ-024 REDIR SHALL hold pc_src, target_pc, flushes until an edge with imem_ready=1, then enter BUBBLE and increment redirect_cnt.
REQ-025 In REDIR a new request of priority >= pending source SHALL overwrite target and source; lower priority SHALL be dropped.
REQ-026 BUBBLE SHALL last one cycle with pc_src=0, flushes=0, fetch_valid=0, then RUN; a redirect in BUBBLE SHALL enter REDIR directly.
REQ-027 In RUN, stall SHALL equal hz_stall | !imem_ready (registered); in REDIR stall SHALL be 0 (redirect overrides hz_stall).
REQ-028 fetch_valid SHALL equal (state==RUN) & imem_ready.
REQ-029 redirect_cnt SHALL wrap 16'hFFFF -> 16'h0000.

Reset
REQ-030 reset low SHALL immediately force state=BOOT, boot counter=0, pc_src=0, target_pc=0, stall=1, flush_if_id=0, flush_id_ex=0, redirect_cnt=0.
REQ-031 reset asserted mid-REDIR SHALL discard the pending redirect without incrementing redirect_cnt.

Structure
REQ-032 Package fetch_pkg SHALL hold state encoding, redirect-source encoding (NONE/JUMP/BRANCH/TRAP), RESET_PC, default TRAP_VECTOR.
REQ-033 Sub-module redirect_arb SHALL be the combinational priority selector returning source and target.

Verification
REQ-034 Reset release, imem_ready=1, BOOT_CYCLES=2 -> stall=1 two cycles, then stall=0, fetch_valid=1.
REQ-035 RUN, ex_br_taken=1 target 0x0C one cycle -> next cycle pc_src=1, target_pc=0x0C, flush_if_id=1, flush_id_ex=1; then BUBBLE; redirect_cnt=1.
REQ-036 id_jump (0x40) and trap_req same cycle -> target_pc=0x100, flush_id_ex=1; jump dropped.
REQ-037 REDIR to 0x0C with imem_ready=0 three cycles, ex_br 0x20 in second -> pc_src held, target_pc=0x20, single increment on ready.
REQ-038 hz_stall=1 in RUN -> stall=1 next cycle; hz_stall=1 with id_jump -> stall=0, pc_src=1.
REQ-039 redirect_cnt preloaded via 65535 redirects -> next redirect gives 0; reset during REDIR -> stall=1, pc_src=0 immediately.
